multicycle_cpu: RTL and testbench
=================================

# multicycle_cpu

Parametrised multi-cycle successor to the single-cycle RV32I-subset core. Instructions execute over several states of one FSM that shares a single ALU and a single unified instruction/data memory port with a ready handshake, so slow memories stall the core. Adds taken branches, halt-on-error, and a retired-instruction counter. Sits at top level between the testbench/SoC memory model and nothing else.

## Interface
- XLEN, 32: datapath/register width; must be ≥32; immediates sign-extend to XLEN.
- NREGS, 32: architectural registers, 16 or 32 (16 = RV32E).
- RESET_PC, 0: first fetch address.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = store, 0 = read (fetch or load).
- mem_addr  out  XLEN  byte address, word-aligned.
- mem_wdata  out  XLEN  store data.
- mem_rdata  in  XLEN  read data, valid in the cycle mem_ready=1.
- mem_ready  in  1  transaction completes at the edge where mem_req=1 and mem_ready=1.
- halted  out  1  core stopped in HALT.
- instret  out  XLEN  retired-instruction count.

## Operation
- Supported: R-type ADD, SUB, AND, OR, XOR, SLT, SLTU; ADDI; LW; SW; BEQ; BNE. Anything else (including all-zero word) is illegal → HALT.
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT.
- BOOT: one cycle after reset release; all outputs 0; → FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc; on completion latch IR, old_pc=pc, pc=pc+4 → DECODE. pc[1:0]≠0 on entry → HALT, no request issued.
- DECODE: read rs1/rs2 into A/B; illegal opcode/funct or any register index ≥ NREGS → HALT (not retired).
- EXEC: R/ADDI: ALU result → WB. LW/SW: address = A + sext(imm); addr[1:0]≠0 → HALT without access; else → MEM. BEQ/BNE: compare A,B; if taken pc = old_pc + sext(B-imm); retire → FETCH.
- MEM: mem_req=1, mem_addr latched, mem_we=1 and mem_wdata=B for SW; on completion SW retires → FETCH; LW latches mem_rdata → WB.
- WB: write rd (writes to x0 discarded; x0 reads 0); retire → FETCH.
- Retire: instret increments by 1, wraps at 2^XLEN.
- HALT: absorbing until reset; halted=1, mem_req=0.
- mem_addr/mem_we/mem_wdata held stable while mem_req=1 and mem_ready=0.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, instret=0, pc=RESET_PC, all registers 0, state=BOOT.
- mem_ready tied 1: branch 3 cycles; R/ADDI/SW 4; LW 5. Each cycle of mem_ready=0 in FETCH or MEM adds one cycle.
- mem_ready=1 while mem_req=0: ignored.
- mem_req deasserts in the cycle after completion (DECODE/WB/FETCH state change), never back-to-back except MEM→FETCH for SW.
- Register write and instret update take effect at the WB/retire edge; next DECODE sees the new value.
- Reset mid-transaction: everything returns to reset values immediately (async); pending memory transaction abandoned; store in MEM with mem_ready=0 never counted as retired.

## Structure
- Package cpu_pkg: opcode constants (0110011, 0010011, 0000011, 0100011, 1100011), funct3/funct7 constants, state enum, ALU-op enum.
- One sub-module: mc_alu (XLEN-parametrised, ops ADD/SUB/AND/OR/XOR/SLT/SLTU, zero flag). Register file inline as an array of NREGS×XLEN.

## Test plan
- Reset, mem_ready=1, program ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2 → x3=12, instret=3 after 12 cycles from first FETCH.
- SW x3,8(x0) then LW x4,8(x0) with mem_ready low 2 cycles per access → one store with mem_addr=8, mem_wdata=12; x4=12; each access stretched exactly 2 cycles, signals stable.
- BEQ x1,x1,-8 at pc=0x10 → next fetch addr 0x08; BNE x1,x1 → next fetch 0x14; taken branch to 0x0A → HALT with no request.
- LW from address 6 → HALT, no MEM request, instret unchanged; illegal word 0x00000000 → HALT.
- NREGS=16: ADD x20,x1,x2 → HALT; ADDI x0,x0,9 → x0 reads 0.
- Assert reset during MEM with mem_ready=0 → mem_req drops immediately, instret=0, first post-reset fetch at RESET_PC after BOOT cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core: opcode and funct
// encodings, the controller state set and the ALU operation set.
package cpu_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLTU
    } alu_op_e;

    // Map an already-legal R-type funct3/funct7 pair onto an ALU operation.
    function automatic alu_op_e rTypeOp(input logic [2:0] f3, input logic [6:0] f7);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            F3_ADD_SUB: op = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

    // True when a 5-bit register index names an implemented register.
    function automatic logic regInRange(input logic [4:0] idx, input int nregs);
        return (int'({27'b0, idx}) < nregs);
    endfunction

endpackage

// File: rtl/mc_alu.sv
// Single shared ALU: arithmetic/logic results plus a zero flag that the
// controller uses for branch comparison (SUB result == 0 means equal).
module mc_alu
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e          op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    output logic [XLEN-1:0]  y_o,
    output logic             zero_o
);

    // Purely combinational operation select.
    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_AND:  y_o = a_i & b_i;
            ALU_OR:   y_o = a_i | b_i;
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SLT:  y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: y_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            default:  y_o = '0;
        endcase
    end

    assign zero_o = (y_o == '0);

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle RV32I-subset core. One FSM sequences fetch, decode, execute,
// memory and writeback over a single ready-handshaked memory port and a single
// ALU. Illegal instructions and misaligned accesses park the core in HALT.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             mem_ready,
    output logic             halted,
    output logic [XLEN-1:0]  instret
);

    localparam int              IDXW    = $clog2(NREGS);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] ONE     = XLEN'(1);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   oldPc_q, oldPc_d;
    logic [31:0]       ir_q, ir_d;
    logic [XLEN-1:0]   opA_q, opA_d;
    logic [XLEN-1:0]   opB_q, opB_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   memAddr_q, memAddr_d;
    logic [XLEN-1:0]   instret_q, instret_d;
    logic [XLEN-1:0]   regs_q [NREGS];

    logic [6:0]        opcode;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [XLEN-1:0]   immI, immS, immB;
    logic              isR, isAddi, isLoad, isStore, isBranch, legal;
    logic [XLEN-1:0]   rdata1, rdata2;
    logic              regWe;

    alu_op_e           aluOp;
    logic [XLEN-1:0]   aluB, aluY;
    logic              aluZero;
    logic              branchTaken;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];

    assign immI = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    assign immS = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign immB = {{(XLEN-12){ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

    // Instruction classification and legality, including the register-index
    // range check that makes the NREGS=16 build behave as RV32E.
    always_comb begin
        isR      = (opcode == OP_RTYPE) &&
                   (((f7 == F7_BASE) && (f3 != 3'b001) && (f3 != 3'b101)) ||
                    ((f7 == F7_SUB) && (f3 == F3_ADD_SUB)));
        isAddi   = (opcode == OP_IMM) && (f3 == F3_ADD_SUB);
        isLoad   = (opcode == OP_LOAD) && (f3 == F3_WORD);
        isStore  = (opcode == OP_STORE) && (f3 == F3_WORD);
        isBranch = (opcode == OP_BRANCH) && ((f3 == F3_BEQ) || (f3 == F3_BNE));
        legal    = (isR || isAddi || isLoad || isStore || isBranch) &&
                   regInRange(rs1, NREGS) &&
                   (!(isR || isStore || isBranch) || regInRange(rs2, NREGS)) &&
                   (!(isR || isAddi || isLoad) || regInRange(rd, NREGS));
    end

    assign rdata1 = ((rs1 != 5'd0) && regInRange(rs1, NREGS)) ? regs_q[rs1[IDXW-1:0]] : '0;
    assign rdata2 = ((rs2 != 5'd0) && regInRange(rs2, NREGS)) ? regs_q[rs2[IDXW-1:0]] : '0;

    // ALU operand/operation steering for the EXEC state.
    always_comb begin
        aluOp = ALU_ADD;
        aluB  = immI;
        if (isR) begin
            aluOp = rTypeOp(f3, f7);
            aluB  = opB_q;
        end else if (isBranch) begin
            aluOp = ALU_SUB;
            aluB  = opB_q;
        end else if (isStore) begin
            aluB  = immS;
        end
    end

    mc_alu #(.XLEN(XLEN)) u_alu (
        .op_i   (aluOp),
        .a_i    (opA_q),
        .b_i    (aluB),
        .y_o    (aluY),
        .zero_o (aluZero)
    );

    assign branchTaken = (f3 == F3_BEQ) ? aluZero : !aluZero;

    // Controller next-state and memory-port outputs; the port is driven only
    // in FETCH/MEM so its signals stay constant while a transaction stalls.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        oldPc_d   = oldPc_q;
        ir_d      = ir_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        result_d  = result_q;
        memAddr_d = memAddr_q;
        instret_d = instret_q;
        regWe     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (pc_q[1:0] != 2'b00) begin
                    state_d = ST_HALT;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = pc_q;
                    if (mem_ready) begin
                        ir_d    = mem_rdata[31:0];
                        oldPc_d = pc_q;
                        pc_d    = pc_q + PC_STEP;
                        state_d = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                if (!legal) begin
                    state_d = ST_HALT;
                end else begin
                    opA_d   = rdata1;
                    opB_d   = rdata2;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (isBranch) begin
                    if (branchTaken) begin
                        pc_d = oldPc_q + immB;
                    end
                    instret_d = instret_q + ONE;
                    state_d   = ST_FETCH;
                end else if (isLoad || isStore) begin
                    if (aluY[1:0] != 2'b00) begin
                        state_d = ST_HALT;
                    end else begin
                        memAddr_d = aluY;
                        state_d   = ST_MEM;
                    end
                end else begin
                    result_d = aluY;
                    state_d  = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_addr = memAddr_q;
                if (isStore) begin
                    mem_we    = 1'b1;
                    mem_wdata = opB_q;
                end
                if (mem_ready) begin
                    if (isStore) begin
                        instret_d = instret_q + ONE;
                        state_d   = ST_FETCH;
                    end else begin
                        result_d = mem_rdata;
                        state_d  = ST_WB;
                    end
                end
            end
            ST_WB: begin
                regWe     = (rd != 5'd0);
                instret_d = instret_q + ONE;
                state_d   = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    // Controller and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            oldPc_q   <= '0;
            ir_q      <= '0;
            opA_q     <= '0;
            opB_q     <= '0;
            result_q  <= '0;
            memAddr_q <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            oldPc_q   <= oldPc_d;
            ir_q      <= ir_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            result_q  <= result_d;
            memAddr_q <= memAddr_d;
            instret_q <= instret_d;
        end
    end

    // Architectural register file; x0 is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (regWe) begin
            regs_q[rd[IDXW-1:0]] <= result_q;
        end
    end

    assign halted  = (state_q == ST_HALT);
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: a word memory model with a programmable
// stall count drives the main core; a second RV32E core checks register limits.
module tb_multicycle_cpu;

    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, instret;

    logic        rst16 = 1'b1;
    logic        req16, we16, halted16;
    logic [31:0] addr16, wdata16, instret16;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [64];
    logic [31:0] mem16 [16];
    int          stallN = 0;
    int          waitCnt = 0;
    int          stabErr = 0;
    logic        holdValid = 1'b0;
    logic        holdWe = 1'b0;
    logic [31:0] holdAddr = '0;
    logic [31:0] holdWdata = '0;
    logic [31:0] storeAddrQ[$];
    logic [31:0] storeDataQ[$];
    logic [31:0] readQ[$];
    int          lenQ[$];
    logic [31:0] store16AddrQ[$];
    logic [31:0] store16DataQ[$];

    always #5 clk = ~clk;

    multicycle_cpu #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .halted(halted), .instret(instret)
    );

    multicycle_cpu #(.XLEN(32), .NREGS(16), .RESET_PC(32'h0)) dut16 (
        .clk(clk), .reset(rst16), .mem_req(req16), .mem_we(we16),
        .mem_addr(addr16), .mem_wdata(wdata16), .mem_rdata(mem16[addr16[5:2]]),
        .mem_ready(1'b1), .halted(halted16), .instret(instret16)
    );

    assign mem_ready = (waitCnt >= stallN);
    assign mem_rdata = mem[mem_addr[7:2]];

    // Memory model: completes a transaction after stallN waiting cycles, logs
    // every completion and counts any port change during a stall.
    always @(posedge clk) begin
        if (mem_req) begin
            if (holdValid && (mem_addr !== holdAddr || mem_we !== holdWe || mem_wdata !== holdWdata))
                stabErr <= stabErr + 1;
            if (mem_ready) begin
                lenQ.push_back(waitCnt);
                if (mem_we) begin
                    mem[mem_addr[7:2]] = mem_wdata;
                    storeAddrQ.push_back(mem_addr);
                    storeDataQ.push_back(mem_wdata);
                end else begin
                    readQ.push_back(mem_addr);
                end
                waitCnt   <= 0;
                holdValid <= 1'b0;
            end else begin
                waitCnt   <= waitCnt + 1;
                holdValid <= 1'b1;
                holdAddr  <= mem_addr;
                holdWe    <= mem_we;
                holdWdata <= mem_wdata;
            end
        end else begin
            waitCnt   <= 0;
            holdValid <= 1'b0;
        end
    end

    // Always-ready memory for the RV32E core, logging stores only.
    always @(posedge clk) begin
        if (req16 && we16) begin
            mem16[addr16[5:2]] = wdata16;
            store16AddrQ.push_back(addr16);
            store16DataQ.push_back(wdata16);
        end
    end

    function automatic logic [31:0] encR(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] encI(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] encS(input int imm, input int rs2, input int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] encB(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic holdReset();
        @(negedge clk);
        reset  = 1'b1;
        stallN = 0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        storeAddrQ.delete();
        storeDataQ.delete();
        readQ.delete();
        lenQ.delete();
        #1;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitHalted(input int maxCycles, output bit timedOut);
        timedOut = 1'b1;
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge clk);
            if (halted) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    // Reset values, the BOOT cycle, then the first fetch at RESET_PC.
    task automatic test_reset();
        holdReset();
        mem[0] = encI(5, 0, 0, 1, OP_IMM);
        mem[1] = encI(7, 0, 0, 2, OP_IMM);
        mem[2] = encR(0, 2, 1, 0, 3);
        mem[3] = encS(240, 3, 0);
        mem[4] = encR(32, 2, 1, 0, 4);
        mem[5] = encS(240, 4, 0);
        mem[6] = encR(0, 2, 1, 7, 5);
        mem[7] = encS(240, 5, 0);
        mem[8] = encR(0, 2, 1, 6, 6);
        mem[9] = encS(240, 6, 0);
        mem[10] = encR(0, 2, 1, 4, 7);
        mem[11] = encS(240, 7, 0);
        mem[12] = encR(0, 1, 4, 2, 8);
        mem[13] = encS(240, 8, 0);
        mem[14] = encR(0, 1, 4, 3, 9);
        mem[15] = encS(240, 9, 0);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %0b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %0b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %0h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %0h want 0", mem_wdata); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %0b want 0", halted); end
        checks++; if (instret !== 32'h0) begin errors++; $display("[TB] FAIL reset_instret: got %0h want 0", instret); end
        releaseReset();
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL boot_req: got %0b want 0", mem_req); end
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_we !== 1'b0)
            begin errors++; $display("[TB] FAIL first_fetch: got req=%0b addr=%0h we=%0b want 1/0/0", mem_req, mem_addr, mem_we); end
    endtask

    // Continues the program loaded by test_reset: exact ADDI/ADD timing, then
    // every R-type result observed through a store.
    task automatic test_alu();
        logic [31:0] expData [7];
        bit timedOut;
        expData = '{32'd12, 32'hFFFFFFFE, 32'd5, 32'd7, 32'd2, 32'd1, 32'd0};
        repeat (11) @(posedge clk);
        #1;
        checks++; if (instret !== 32'd2) begin errors++; $display("[TB] FAIL instret_c11: got %0d want 2", instret); end
        @(posedge clk); #1;
        checks++; if (instret !== 32'd3) begin errors++; $display("[TB] FAIL instret_c12: got %0d want 3", instret); end
        waitHalted(400, timedOut);
        checks++; if (timedOut) begin errors++; $display("[TB] FAIL alu_halt_timeout: got running want halted"); end
        checks++; if (storeDataQ.size() != 7) begin errors++; $display("[TB] FAIL alu_store_count: got %0d want 7", storeDataQ.size()); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (i >= storeDataQ.size() || storeDataQ[i] !== expData[i] || storeAddrQ[i] !== 32'd240) begin
                errors++;
                $display("[TB] FAIL alu_store%0d: got %0h want %0h at 0xf0", i,
                         (i < storeDataQ.size()) ? storeDataQ[i] : 32'hx, expData[i]);
            end
        end
        checks++; if (instret !== 32'd16) begin errors++; $display("[TB] FAIL alu_instret: got %0d want 16", instret); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_req: got %0b want 0", mem_req); end
    endtask

    // Store then load through a memory that stalls every access by two cycles.
    task automatic test_load_store();
        bit timedOut;
        int stab0;
        int badLen;
        holdReset();
        stallN = 2;
        mem[0]  = encB(32, 0, 0, 0);
        mem[8]  = encI(12, 0, 0, 3, OP_IMM);
        mem[9]  = encS(8, 3, 0);
        mem[10] = encI(8, 0, 2, 4, OP_LOAD);
        mem[11] = encS(240, 4, 0);
        stab0 = stabErr;
        releaseReset();
        waitHalted(500, timedOut);
        checks++; if (timedOut) begin errors++; $display("[TB] FAIL ls_halt_timeout: got running want halted"); end
        checks++; if (storeDataQ.size() != 2) begin errors++; $display("[TB] FAIL ls_store_count: got %0d want 2", storeDataQ.size()); end
        checks++; if (storeAddrQ.size() < 1 || storeAddrQ[0] !== 32'd8 || storeDataQ[0] !== 32'd12)
            begin errors++; $display("[TB] FAIL ls_sw: got addr/data %0h/%0h want 8/c",
                  (storeAddrQ.size() > 0) ? storeAddrQ[0] : 32'hx, (storeDataQ.size() > 0) ? storeDataQ[0] : 32'hx); end
        checks++; if (storeAddrQ.size() < 2 || storeAddrQ[1] !== 32'd240 || storeDataQ[1] !== 32'd12)
            begin errors++; $display("[TB] FAIL ls_lw_value: got %0h want c",
                  (storeDataQ.size() > 1) ? storeDataQ[1] : 32'hx); end
        checks++; if (lenQ.size() != 9) begin errors++; $display("[TB] FAIL ls_txn_count: got %0d want 9", lenQ.size()); end
        badLen = 0;
        foreach (lenQ[i]) if (lenQ[i] != 2) badLen++;
        checks++; if (badLen != 0) begin errors++; $display("[TB] FAIL ls_stretch: got %0d accesses not 2 cycles want 0", badLen); end
        checks++; if (stabErr != stab0) begin errors++; $display("[TB] FAIL ls_stable: got %0d changes want 0", stabErr - stab0); end
        checks++; if (instret !== 32'd5) begin errors++; $display("[TB] FAIL ls_instret: got %0d want 5", instret); end
    endtask

    // Taken/not-taken branches and a taken branch to a misaligned target.
    task automatic test_branch();
        logic [31:0] expPc [5];
        bit timedOut;
        expPc = '{32'h00, 32'h04, 32'h10, 32'h08, 32'h0C};
        holdReset();
        mem[0] = encI(1, 0, 0, 1, OP_IMM);
        mem[1] = encB(12, 0, 0, 0);
        mem[2] = encB(100, 1, 1, 1);
        mem[3] = encB(-2, 0, 0, 0);
        mem[4] = encB(-8, 1, 1, 0);
        releaseReset();
        waitHalted(200, timedOut);
        checks++; if (timedOut) begin errors++; $display("[TB] FAIL br_halt_timeout: got running want halted"); end
        checks++; if (readQ.size() != 5) begin errors++; $display("[TB] FAIL br_fetch_count: got %0d want 5", readQ.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= readQ.size() || readQ[i] !== expPc[i]) begin
                errors++;
                $display("[TB] FAIL br_fetch%0d: got %0h want %0h", i, (i < readQ.size()) ? readQ[i] : 32'hx, expPc[i]);
            end
        end
        checks++; if (instret !== 32'd5) begin errors++; $display("[TB] FAIL br_instret: got %0d want 5", instret); end
    endtask

    // Misaligned load address and an illegal R-type funct combination.
    task automatic test_halt_errors();
        bit timedOut;
        holdReset();
        mem[0] = encI(1, 0, 0, 1, OP_IMM);
        mem[1] = encI(6, 0, 2, 2, OP_LOAD);
        releaseReset();
        waitHalted(100, timedOut);
        checks++; if (timedOut) begin errors++; $display("[TB] FAIL mis_halt_timeout: got running want halted"); end
        checks++; if (lenQ.size() != 2) begin errors++; $display("[TB] FAIL mis_txn_count: got %0d want 2", lenQ.size()); end
        checks++; if (instret !== 32'd1) begin errors++; $display("[TB] FAIL mis_instret: got %0d want 1", instret); end
        holdReset();
        mem[0] = encI(1, 0, 0, 1, OP_IMM);
        mem[1] = encR(32, 2, 1, 7, 3);
        releaseReset();
        waitHalted(100, timedOut);
        checks++; if (timedOut) begin errors++; $display("[TB] FAIL ill_halt_timeout: got running want halted"); end
        checks++; if (instret !== 32'd1 || lenQ.size() != 2)
            begin errors++; $display("[TB] FAIL ill_state: got instret=%0d txns=%0d want 1/2", instret, lenQ.size()); end
    endtask

    // Reset while a store is stalled in MEM: abandoned, not retired, reboots.
    task automatic test_reset_mid_mem();
        bit found;
        holdReset();
        stallN = 40;
        mem[0] = encI(3, 0, 0, 1, OP_IMM);
        mem[1] = encS(240, 1, 0);
        releaseReset();
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL mid_store_seen: got none want store request"); end
        repeat (3) @(negedge clk);
        checks++; if (instret !== 32'd1) begin errors++; $display("[TB] FAIL mid_pre_instret: got %0d want 1", instret); end
        reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL mid_req_drop: got req=%0b we=%0b want 0/0", mem_req, mem_we); end
        checks++; if (instret !== 32'd0) begin errors++; $display("[TB] FAIL mid_instret: got %0d want 0", instret); end
        checks++; if (storeAddrQ.size() != 0) begin errors++; $display("[TB] FAIL mid_no_store: got %0d stores want 0", storeAddrQ.size()); end
        stallN = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_boot: got req=%0b want 0", mem_req); end
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0)
            begin errors++; $display("[TB] FAIL mid_refetch: got req=%0b addr=%0h want 1/0", mem_req, mem_addr); end
    endtask

    // RV32E build: x0 stays zero, an index of 20 is illegal.
    task automatic test_rv32e();
        bit done;
        for (int i = 0; i < 16; i++) mem16[i] = '0;
        mem16[0] = encI(9, 0, 0, 0, OP_IMM);
        mem16[1] = encS(56, 0, 0);
        mem16[2] = encR(0, 2, 1, 0, 20);
        @(negedge clk);
        rst16 = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (halted16) begin
                done = 1'b1;
                break;
            end
        end
        checks++; if (!done) begin errors++; $display("[TB] FAIL e_halt_timeout: got running want halted"); end
        checks++; if (store16DataQ.size() != 1 || store16AddrQ[0] !== 32'd56 || store16DataQ[0] !== 32'd0)
            begin errors++; $display("[TB] FAIL e_x0_zero: got %0d stores data=%0h want 1 store of 0 at 0x38",
                  store16DataQ.size(), (store16DataQ.size() > 0) ? store16DataQ[0] : 32'hx); end
        checks++; if (instret16 !== 32'd2) begin errors++; $display("[TB] FAIL e_instret: got %0d want 2", instret16); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_halt_errors();
        test_reset_mid_mem();
        test_rv32e();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
